pipe_skid_reg: RTL and testbench
================================

// Module: pipe_skid_reg
// PURPOSE
//  Next-generation pipeline stage register: parametrised data width with valid/ready handshake.
//  Two-entry skid buffer, so in_ready is a registered output with no combinational path from
//  out_ready. Adds flush, occupancy and a saturating stall counter.
//  Sits between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB) of the 5-stage pipeline.
//  Replaces plain enable/clear flops where stages need backpressure.
// PARAMETERS
//  WIDTH       32  payload width in bits (>=1)
//  CLEAR_DATA  1   1: flush and reset zero both data regs; 0: data regs keep their value on flush
//  CNT_W       16  width of stall_cnt (>=1)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous reset, active-low
//  flush      in   1      synchronous: discard all held entries
//  in_valid   in   1      upstream payload valid
//  in_ready   out  1      stage can accept (registered)
//  in_data    in   WIDTH  upstream payload
//  out_valid  out  1      payload available downstream
//  out_ready  in   1      downstream accepts
//  out_data   out  WIDTH  payload to downstream (= main reg)
//  level      out  2      occupancy 0..2
//  stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
// BEHAVIOUR
//  - Reset (rst_n=0, async):
//      state=EMPTY, level=0, out_valid=0, in_ready=0, stall_cnt=0.
//      main/skid data=0 when CLEAR_DATA=1.
//  - in_ready rises at the first clk edge after rst_n deasserts.
//  - Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - States (level): EMPTY(0), ONE(1), FULL(2); out_valid = (state!=EMPTY).
//  - in_ready is registered as (next_state!=FULL) and is never a function of the current out_ready.
//  - EMPTY: in_fire -> main<=in_data, ONE. Latency in->out is 1 cycle.
//  - ONE:   in_fire & out_fire -> main<=in_data, stay ONE.
//           in_fire only -> skid<=in_data, FULL.
//           out_fire only -> EMPTY.
//  - FULL:  in_ready=0. out_fire -> main<=skid, ONE. No input is accepted in FULL.
//  - Ordering: strict FIFO; no payload dropped or duplicated outside flush.
//  - flush=1: next state EMPTY, level=0, in_ready=1 next cycle. In the flush cycle in_valid is
//      ignored even if in_ready=1 (the entry is not accepted). An out_fire in the same cycle
//      counts as delivered. Data regs zeroed if CLEAR_DATA=1.
//  - Priority: rst_n > flush > handshake updates.
//  - stall_cnt: +1 each cycle out_valid & !out_ready; holds at 2^CNT_W-1; unaffected by flush.
//  - out_data is stable while out_valid=1 & out_ready=0.
//  - Reset asserted mid-transfer: all entries discarded immediately; no output glitch beyond the
//      async clear.
// STRUCTURE
//  - Shared package pipe_pkg: localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2; state width 2.
//  - Sub-module pipe_sat_counter #(CNT_W) (clk, rst_n, inc, cnt) for stall_cnt, reusable by other
//      stages.
//  - Main and skid data regs plus a 2-bit state reg in this module; level = state encoding.
// TESTING
//  1. Reset: rst_n=0 mid-stream with FULL state -> out_valid=0, level=0, in_ready=0 immediately;
//     in_ready=1 one edge after release.
//  2. Streaming: out_ready=1, in_valid=1, data 1..8 -> out_data 1..8 one cycle later, level=1,
//     in_ready=1 throughout.
//  3. Backpressure: push A,B with out_ready=0 -> level=2, in_ready=0, out_data=A held;
//     out_ready=1 -> A then B, level 2->1->0.
//  4. Flush while FULL with in_valid=1, data C -> next cycle level=0, out_valid=0, C not delivered;
//     data regs=0 when CLEAR_DATA=1.
//  5. Stall counter: CNT_W=2, hold out_valid=1 & out_ready=0 for 6 cycles -> stall_cnt 1,2,3,3,3,3.
//  6. Random valid/ready, 10k cycles -> scoreboard shows in-order, lossless delivery; in_ready
//     never depends on same-cycle out_ready.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers.
package pipe_pkg;

  localparam int unsigned StateW = 2;

  // The state encoding doubles as the occupancy count.
  localparam logic [StateW-1:0] ST_EMPTY = 2'd0;
  localparam logic [StateW-1:0] ST_ONE   = 2'd1;
  localparam logic [StateW-1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register with registered in_ready, flush,
// occupancy output and saturating stall counter.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter bit          CLEAR_DATA = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       level_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic [StateW-1:0] state_d, state_q;
  logic [WIDTH-1:0]  main_d, main_q;
  logic [WIDTH-1:0]  skid_d, skid_q;
  logic              in_ready_d, in_ready_q;
  logic              in_fire, out_fire;

  assign out_valid_o = (state_q != ST_EMPTY);
  assign in_fire     = in_valid_i & in_ready_q;
  assign out_fire    = out_valid_o & out_ready_i;

  // Next-state and data steering; flush overrides any handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      if (CLEAR_DATA) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = in_data_i;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            skid_d  = in_data_i;
            state_d = ST_FULL;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    // Derived from next state only, so no path from out_ready to in_ready.
    in_ready_d = (state_d != ST_FULL);
  end

  // Stage state and payload registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready_o = in_ready_q;
  assign out_data_o = main_q;
  assign level_o    = state_q;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (out_valid_o & ~out_ready_i),
    .cnt_o  (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and random bench for pipe_skid_reg with a queue-based reference.
module tb_pipe_skid_reg;

  localparam int unsigned W = 32;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    level;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic [W-1:0] q[$];
  int           m_level = 0;
  logic         m_rdy = 1'b0;
  int           m_cnt = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .WIDTH      (W),
    .CLEAR_DATA (1'b1),
    .CNT_W      (CW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .level_o     (level),
    .stall_cnt_o (stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("in_ready", 64'(in_ready), 64'(m_rdy));
    chk("out_valid", 64'(out_valid), 64'(m_level != 0));
    chk("level", 64'(level), 64'(m_level));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    if (m_level != 0) chk("out_data", 64'(out_data), 64'(q[0]));
  endtask

  // Check current outputs, advance the model by one edge, then step the DUT.
  task automatic cycle();
    logic inf, outf, stall;
    check_outputs();
    inf   = in_valid && m_rdy && !flush;
    outf  = (m_level != 0) && out_ready;
    stall = (m_level != 0) && !out_ready;
    if (outf) void'(q.pop_front());
    if (flush) q.delete();
    else if (inf) q.push_back(in_data);
    m_level = q.size();
    m_rdy   = (m_level != 2);
    if (stall && m_cnt != 3) m_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_level = 0;
    m_rdy   = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  initial begin
    // Reset values.
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    #3;
    chk("rst_out_data", 64'(out_data), 64'h0);
    #9;
    rst_n = 1'b1;
    cycle();  // in_ready low before first edge, high after

    // Streaming 1..8 with out_ready high.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b0);
      cycle();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    cycle();
    cycle();

    // Backpressure: A, B with out_ready low, then drain.
    drive(1'b1, 32'hA, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'hDEAD, 1'b0, 1'b0);  // must be refused while full
    cycle();
    chk("bp_level_full", 64'(level), 64'd2);
    chk("bp_out_data_A", 64'(out_data), 64'hA);
    drive(1'b0, '0, 1'b1, 1'b0);
    cycle();
    cycle();
    cycle();
    chk("bp_level_empty", 64'(level), 64'd0);

    // Flush while full with a valid input C.
    drive(1'b1, 32'h1, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h2, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'hC, 1'b0, 1'b1);
    cycle();
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_data_zero", 64'(out_data), 64'h0);
    drive(1'b0, '0, 1'b1, 1'b0);
    cycle();
    cycle();

    // Mid-stream async reset with the stage full.
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h22, 1'b0, 1'b0);
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_level", 64'(level), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
    model_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    cycle();
    chk("arst_in_ready_rel", 64'(in_ready), 64'd1);

    // Stall counter saturation: 1,2,3,3,3,3.
    drive(1'b1, 32'h55, 1'b0, 1'b0);
    cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("stall_sat", 64'(stall_cnt), 64'((i + 1 > 3) ? 3 : i + 1));
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    cycle();

    // Random traffic; in_ready also checked with out_ready toggled mid-cycle.
    for (int n = 0; n < 10000; n++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) == 0));
      out_ready = ~out_ready;
      #1;
      chk("rand_in_ready_indep", 64'(in_ready), 64'(m_rdy));
      out_ready = ~out_ready;
      cycle();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    cycle();
    cycle();
    cycle();
    chk("drain_empty", 64'(level), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
